// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount greedily (10, 5, 2, 1) from coin hoppers.
// Ports:
//   clk, rst_n (synchronous, active-high despite the name)
//   start/amount        : one-cycle request to pay amount (IDLE only)
//   empty_10..empty_1   : hopper empty flags, sampled at each coin selection
//   clr                 : leaves FAULT back to IDLE
//   eject_10..eject_1   : solenoid pulses, EJECT_HI cycles each, at most one high
//   busy, done, fault   : status (done is a one-cycle pulse, fault a level)
//   remaining           : amount still owed
//   coin_count          : coins ejected in this/last payment, saturating at 15
module change_dispenser #(
    parameter int AMT_W     = 7,
    parameter int EJECT_HI  = 2,
    parameter int EJECT_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             empty_10,
    input  logic             empty_5,
    input  logic             empty_2,
    input  logic             empty_1,
    input  logic             clr,
    output logic             eject_10,
    output logic             eject_5,
    output logic             eject_2,
    output logic             eject_1,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [3:0]       coin_count
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} state_t;

    state_t           state, state_nx;
    logic [AMT_W-1:0] rem_nx, d_val;
    logic [3:0]       cc_nx, sel, sel_nx, pick;
    logic [7:0]       cnt, cnt_nx;
    logic             ok10, ok5, ok2, ok1;

    // sel/pick are one-hot {10, 5, 2, 1}
    assign ok10  = !empty_10 && remaining >= AMT_W'(10);
    assign ok5   = !empty_5  && remaining >= AMT_W'(5);
    assign ok2   = !empty_2  && remaining >= AMT_W'(2);
    assign ok1   = !empty_1  && remaining >= AMT_W'(1);
    assign pick  = ok10 ? 4'b1000 : ok5 ? 4'b0100 : ok2 ? 4'b0010 : ok1 ? 4'b0001 : 4'b0000;
    assign d_val = sel[3] ? AMT_W'(10) : sel[2] ? AMT_W'(5) : sel[1] ? AMT_W'(2) : AMT_W'(1);

    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        cc_nx    = coin_count;
        cnt_nx   = cnt;
        sel_nx   = sel;
        case (state)
            IDLE: if (start) begin
                rem_nx   = amount;
                cc_nx    = 4'd0;
                state_nx = SELECT;
            end
            SELECT: begin
                cnt_nx   = 8'd0;
                sel_nx   = pick;
                state_nx = remaining == '0 ? DONE : pick != 4'b0000 ? EJECT : FAULT;
            end
            EJECT: if (cnt == 8'(EJECT_HI - 1)) begin
                cnt_nx   = 8'd0;
                rem_nx   = remaining - d_val;
                cc_nx    = coin_count == 4'd15 ? 4'd15 : coin_count + 4'd1;
                state_nx = GAP;
            end else begin
                cnt_nx = cnt + 8'd1;
            end
            GAP: if (cnt == 8'(EJECT_GAP - 1)) begin
                cnt_nx   = 8'd0;
                state_nx = SELECT;
            end else begin
                cnt_nx = cnt + 8'd1;
            end
            DONE:    state_nx = IDLE;
            FAULT:   state_nx = clr ? IDLE : FAULT;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            sel        <= 4'b0000;
            remaining  <= '0;
            coin_count <= 4'd0;
            {eject_10, eject_5, eject_2, eject_1} <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            remaining  <= rem_nx;
            coin_count <= cc_nx;
            {eject_10, eject_5, eject_2, eject_1} <= state_nx == EJECT ? sel_nx : 4'b0000;
            busy       <= state_nx != IDLE;
            done       <= state_nx == DONE;
            fault      <= state_nx == FAULT;
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed self-checking bench for change_dispenser.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst_n, start, clr, empty_10, empty_5, empty_2, empty_1;
    logic [6:0] amount;
    logic       eject_10, eject_5, eject_2, eject_1, busy, done, fault;
    logic [6:0] remaining;
    logic [3:0] coin_count;

    int errors = 0;
    int checks = 0;

    logic [3:0] tr_ej    [0:63];
    logic       tr_done  [0:63];
    logic       tr_busy  [0:63];
    logic       tr_fault [0:63];
    int         seq_code;
    int         done_cnt;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
        .empty_10(empty_10), .empty_5(empty_5), .empty_2(empty_2), .empty_1(empty_1),
        .clr(clr), .eject_10(eject_10), .eject_5(eject_5), .eject_2(eject_2),
        .eject_1(eject_1), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int c);
        tr_ej[c]    = {eject_10, eject_5, eject_2, eject_1};
        tr_done[c]  = done;
        tr_busy[c]  = busy;
        tr_fault[c] = fault;
    endtask

    // Pulses start in cycle 0 and records cycles 0..n; coins are packed one hex digit each (10 -> A).
    task automatic run(input logic [6:0] amt, input int n);
        amount = amt;
        start  = 1'b1;
        snap(0);
        tick;
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) tick;
            snap(c);
        end
        seq_code = 0;
        done_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (tr_ej[c] != 4'b0000 && tr_ej[c-1] == 4'b0000)
                seq_code = seq_code * 16 + (tr_ej[c][3] ? 10 : tr_ej[c][2] ? 5 : tr_ej[c][1] ? 2 : 1);
            if (tr_done[c]) done_cnt++;
            checks++;
            if ($countones(tr_ej[c]) > 1) begin
                errors++;
                $display("FAIL onehot cycle %0d: eject=%b, required at most one bit", c, tr_ej[c]);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({eject_10, eject_5, eject_2, eject_1, busy, done, fault} !== 7'b0 ||
            remaining !== 7'd0 || coin_count !== 4'd0) begin
            errors++;
            $display("FAIL %s: ej=%b busy=%b done=%b fault=%b rem=%0d cc=%0d, required all zero",
                     name, {eject_10, eject_5, eject_2, eject_1}, busy, done, fault, remaining, coin_count);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; clr = 1'b0; amount = 7'd0;
        {empty_10, empty_5, empty_2, empty_1} = 4'b0000;
        tick; tick;
        rst_n = 1'b0;
        check_idle_zero("reset");
        tick;
        check_idle_zero("reset_idle");
    endtask

    task automatic test_pay18;
        logic [3:0] exp_ej;
        run(7'd18, 26);
        for (int c = 0; c <= 26; c++) begin
            exp_ej = (c == 2 || c == 3)   ? 4'b1000 :
                     (c == 7 || c == 8)   ? 4'b0100 :
                     (c == 12 || c == 13) ? 4'b0010 :
                     (c == 17 || c == 18) ? 4'b0001 : 4'b0000;
            checks++;
            if (tr_ej[c] !== exp_ej || tr_done[c] !== (c == 22) || tr_busy[c] !== (c >= 1 && c <= 22)) begin
                errors++;
                $display("FAIL pay18 cycle %0d: ej=%b done=%b busy=%b, required ej=%b done=%b busy=%b",
                         c, tr_ej[c], tr_done[c], tr_busy[c], exp_ej, c == 22, c >= 1 && c <= 22);
            end
        end
        checks++;
        if (coin_count !== 4'd4 || remaining !== 7'd0) begin
            errors++;
            $display("FAIL pay18_end: cc=%0d rem=%0d, required cc=4 rem=0", coin_count, remaining);
        end
    endtask

    task automatic test_zero;
        run(7'd0, 5);
        checks++;
        if (seq_code !== 0 || tr_done[2] !== 1'b1 || done_cnt !== 1 || coin_count !== 4'd0) begin
            errors++;
            $display("FAIL zero: seq=%h done2=%b dones=%0d cc=%0d, required seq=0 done2=1 dones=1 cc=0",
                     seq_code, tr_done[2], done_cnt, coin_count);
        end
    endtask

    task automatic test_empty10;
        empty_10 = 1'b1;
        run(7'd12, 20);
        empty_10 = 1'b0;
        checks++;
        if (seq_code !== 'h552 || done_cnt !== 1 || tr_done[17] !== 1'b1 || coin_count !== 4'd3 || remaining !== 7'd0) begin
            errors++;
            $display("FAIL empty10: seq=%h dones=%0d done17=%b cc=%0d rem=%0d, required seq=552 dones=1 done17=1 cc=3 rem=0",
                     seq_code, done_cnt, tr_done[17], coin_count, remaining);
        end
    endtask

    task automatic test_fault_clr;
        empty_1 = 1'b1;
        run(7'd3, 9);
        checks++;
        if (seq_code !== 'h2 || tr_fault[6] !== 1'b0 || tr_fault[7] !== 1'b1 || fault !== 1'b1 ||
            busy !== 1'b1 || remaining !== 7'd1 || coin_count !== 4'd1) begin
            errors++;
            $display("FAIL fault_e1: seq=%h f6=%b f7=%b fault=%b busy=%b rem=%0d cc=%0d, required seq=2 f6=0 f7=1 fault=1 busy=1 rem=1 cc=1",
                     seq_code, tr_fault[6], tr_fault[7], fault, busy, remaining, coin_count);
        end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        empty_1 = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 7'd1 || coin_count !== 4'd1) begin
            errors++;
            $display("FAIL clr: fault=%b busy=%b rem=%0d cc=%0d, required fault=0 busy=0 rem=1 cc=1",
                     fault, busy, remaining, coin_count);
        end
    endtask

    task automatic test_fault_now;
        empty_2 = 1'b1;
        empty_1 = 1'b1;
        run(7'd3, 3);
        checks++;
        if (seq_code !== 0 || tr_fault[1] !== 1'b0 || tr_fault[2] !== 1'b1 || remaining !== 7'd3) begin
            errors++;
            $display("FAIL fault_now: seq=%h f1=%b f2=%b rem=%0d, required seq=0 f1=0 f2=1 rem=3",
                     seq_code, tr_fault[1], tr_fault[2], remaining);
        end
        empty_2 = 1'b0;
        empty_1 = 1'b0;
        amount  = 7'd5;
        start   = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        checks++;
        if (fault !== 1'b1 || busy !== 1'b1 || remaining !== 7'd3 ||
            {eject_10, eject_5, eject_2, eject_1} !== 4'b0000) begin
            errors++;
            $display("FAIL start_in_fault: fault=%b busy=%b rem=%0d ej=%b, required fault=1 busy=1 rem=3 ej=0000",
                     fault, busy, remaining, {eject_10, eject_5, eject_2, eject_1});
        end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr2: fault=%b busy=%b, required 0 0", fault, busy);
        end
    endtask

    task automatic test_reset_mid;
        run(7'd127, 7);
        checks++;
        if (eject_10 !== 1'b1 || seq_code !== 'hAA) begin
            errors++;
            $display("FAIL mid_eject: eject_10=%b seq=%h, required 1 AA", eject_10, seq_code);
        end
        rst_n = 1'b1;
        tick;
        check_idle_zero("reset_mid");
        rst_n = 1'b0;
        tick;
        run(7'd4, 14);
        checks++;
        if (seq_code !== 'h22 || done_cnt !== 1 || tr_done[12] !== 1'b1 || coin_count !== 4'd2 || remaining !== 7'd0) begin
            errors++;
            $display("FAIL after_reset: seq=%h dones=%0d done12=%b cc=%0d rem=%0d, required seq=22 dones=1 done12=1 cc=2 rem=0",
                     seq_code, done_cnt, tr_done[12], coin_count, remaining);
        end
    endtask

    initial begin
        test_reset;
        test_pay18;
        test_zero;
        test_empty10;
        test_fault_clr;
        test_fault_now;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of the price/credit calculation stage. Consumes the 7-bit change amount that stage produces and drives the coin-hopper eject solenoids. Pays the change greedily (10, 5, 2, 1), skips denominations whose hopper reports empty, and flags a fault when exact change cannot be paid. The system controller starts it with a one-cycle start pulse and waits for done or fault.

Parameters:
AMT_W, 7, width of amount input and remaining output
EJECT_HI, 2, cycles each eject pulse is held high (>=1)
EJECT_GAP, 2, idle cycles after each eject pulse before the next selection (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (asserted = 1) despite the name
start  in  1  one-cycle request to pay amount; honoured only in IDLE
amount  in  AMT_W  change value in units, sampled on the start cycle
empty_10  in  1  10-unit hopper empty
empty_5  in  1  5-unit hopper empty
empty_2  in  1  2-unit hopper empty
empty_1  in  1  1-unit hopper empty
clr  in  1  clears FAULT and returns to IDLE; ignored in other states
eject_10  out  1  10-unit solenoid pulse
eject_5  out  1  5-unit solenoid pulse
eject_2  out  1  2-unit solenoid pulse
eject_1  out  1  1-unit solenoid pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: payment complete
fault  out  1  level: exact change impossible; held until clr
remaining  out  AMT_W  amount still owed
coin_count  out  4  coins ejected in the current or last payment; saturates at 15

Behaviour:
- Reset (rst_n=1 at a clk edge): state goes to IDLE. All eject outputs, busy, done and fault = 0. remaining = 0, coin_count = 0. Reset has priority over all inputs, including in the middle of an eject pulse; the eject drops low the next cycle.
- States: IDLE, SELECT, EJECT, GAP, DONE, FAULT. All outputs are registered.
- IDLE: on start=1, load remaining <= amount, clear coin_count, go to SELECT. busy = 1 from the next cycle.
- start while not in IDLE is ignored. amount is not resampled.
- SELECT (1 cycle):
  - remaining == 0: go to DONE.
  - Otherwise pick the largest d in {10, 5, 2, 1} with d <= remaining and empty_d = 0, then go to EJECT.
  - No such d: go to FAULT.
  - Empty flags are sampled only in SELECT.
- EJECT: assert only eject_d for exactly EJECT_HI cycles. At most one eject output is high in any cycle. On leaving EJECT: remaining <= remaining - d, coin_count <= coin_count + 1 (saturating). Then go to GAP.
- GAP: all ejects low for EJECT_GAP cycles, then go to SELECT.
- Cost per coin: 1 + EJECT_HI + EJECT_GAP cycles.
- DONE: done = 1 for exactly one cycle, then go to IDLE. remaining = 0 and coin_count is held until the next start.
- FAULT: fault = 1, busy = 1. remaining holds the unpaid amount. On clr=1, go to IDLE next cycle with fault = 0; remaining and coin_count are held.
- amount = 0 completes with no ejects: SELECT then DONE.
- A hopper going empty during EJECT or GAP does not affect the coin in flight; it takes effect at the next SELECT.
- remaining never underflows, because d <= remaining is guaranteed at selection.

Test Plan:
- Defaults, all hoppers full, start at cycle 0 with amount=18 -> eject_10 high cycles 2-3, eject_5 cycles 7-8, eject_2 cycles 12-13, eject_1 cycles 17-18; done high only in cycle 22; coin_count=4; remaining=0; busy high cycles 1-22.
- amount=0 -> no ejects; done high in cycle 2; coin_count=0.
- empty_10=1, amount=12 -> coin sequence 5, 5, 2; done; coin_count=3.
- empty_1=1, amount=3 -> one eject_2, then fault=1 with remaining=1 and coin_count=1; clr=1 -> IDLE next cycle, fault=0, busy=0.
- empty_2=1 and empty_1=1, amount=3 -> fault at cycle 2 with no ejects and remaining=3; a start pulse while in FAULT is ignored.
- amount=127, rst_n=1 during the second coin's eject -> next cycle all outputs reset values; a subsequent start with amount=4 pays 2, 2 normally.
